// File: rtl/tensor_core_pkg.sv
// Shared tensor-core types and defaults: embedding geometry and the embedder FSM states.
package tensor_core_pkg;

  localparam int TC_EMB_DIM   = 4;
  localparam int TC_EMB_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } embedder_state_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/token_embedder.sv
// Walks the encoder's token-id RAM, looks each id up in the embedding ROM and writes
// the vectors row-major into the activation RAM; out-of-vocabulary ids give zero vectors.
module token_embedder
  import tensor_core_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int VOCAB_SIZE = 16,
  parameter int EMB_DIM    = TC_EMB_DIM,
  parameter int EMB_WIDTH  = TC_EMB_WIDTH,
  localparam int EMB_ADDR_WIDTH = $clog2(VOCAB_SIZE) + $clog2(EMB_DIM),
  localparam int ACT_ADDR_WIDTH = ADDR_WIDTH + $clog2(EMB_DIM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs,
  input  logic                      enc_done,
  input  logic [ADDR_WIDTH:0]       n_tokens,
  output logic                      tok_re,
  output logic [ADDR_WIDTH-1:0]     tok_addr,
  input  logic [DATA_WIDTH-1:0]     tok_data,
  output logic                      emb_re,
  output logic [EMB_ADDR_WIDTH-1:0] emb_addr,
  input  logic [EMB_WIDTH-1:0]      emb_data,
  output logic                      act_we,
  output logic [ACT_ADDR_WIDTH-1:0] act_addr,
  output logic [EMB_WIDTH-1:0]      act_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int VW = $clog2(VOCAB_SIZE);
  localparam int JW = $clog2(EMB_DIM);
  localparam logic [DATA_WIDTH:0] VOCAB_LIM = (DATA_WIDTH + 1)'(VOCAB_SIZE);
  localparam logic [ADDR_WIDTH:0] N_ONE     = 1;
  localparam logic [ADDR_WIDTH-1:0] I_ONE   = 1;
  localparam logic [JW-1:0] J_ONE           = 1;
  localparam logic [JW-1:0] J_LAST          = '1;

  // Address generation is pure concatenation, so both sizes must be powers of two.
  if (!is_pow2(EMB_DIM) || EMB_DIM < 2) begin : g_bad_dim
    $error("token_embedder: EMB_DIM must be a power of two >= 2");
  end
  if (!is_pow2(VOCAB_SIZE) || VOCAB_SIZE < 2) begin : g_bad_vocab
    $error("token_embedder: VOCAB_SIZE must be a power of two >= 2");
  end

  embedder_state_t           r_state;
  logic [ADDR_WIDTH-1:0]     r_i;
  logic [JW-1:0]             r_j;
  logic [ADDR_WIDTH:0]       r_n;
  logic [VW-1:0]             r_id;
  logic                      r_bad;
  logic                      r_err;
  logic                      r_tok_re;
  logic [ADDR_WIDTH-1:0]     r_tok_addr;
  logic                      r_emb_re;
  logic [EMB_ADDR_WIDTH-1:0] r_emb_addr;
  logic                      r_act_we;
  logic [ACT_ADDR_WIDTH-1:0] r_act_addr;
  logic                      r_busy;
  logic                      r_done;

  logic                      w_bad;
  logic                      w_last;
  logic [JW-1:0]             w_j_nxt;
  logic [ADDR_WIDTH-1:0]     w_i_nxt;

  assign w_bad   = ({1'b0, tok_data} >= VOCAB_LIM);
  assign w_last  = ({1'b0, r_i} == (r_n - N_ONE));
  assign w_j_nxt = r_j + J_ONE;
  assign w_i_nxt = r_i + I_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_n        <= '0;
      r_id       <= '0;
      r_bad      <= 1'b0;
      r_err      <= 1'b0;
      r_tok_re   <= 1'b0;
      r_tok_addr <= '0;
      r_emb_re   <= 1'b0;
      r_emb_addr <= '0;
      r_act_we   <= 1'b0;
      r_act_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tok_re <= 1'b0;
      r_emb_re <= 1'b0;
      r_act_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cs && enc_done) begin
            r_err <= 1'b0;
            r_bad <= 1'b0;
            r_i   <= '0;
            r_j   <= '0;
            r_n   <= n_tokens;
            if (n_tokens == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= FETCH;
              r_busy     <= 1'b1;
              r_tok_re   <= 1'b1;
              r_tok_addr <= '0;
            end
          end
        end
        FETCH: begin
          if (!cs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= LATCH;
          end
        end
        LATCH: begin
          if (!cs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            // Bad ids still walk every element so the zero vector lands in the activation RAM.
            r_id       <= tok_data[VW-1:0];
            r_bad      <= w_bad;
            if (w_bad) r_err <= 1'b1;
            r_state    <= READ;
            r_emb_re   <= !w_bad;
            r_emb_addr <= {tok_data[VW-1:0], r_j};
          end
        end
        READ: begin
          if (!cs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= WRITE;
            r_act_we   <= 1'b1;
            r_act_addr <= {r_i, r_j};
          end
        end
        WRITE: begin
          if (!cs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_j != J_LAST) begin
            r_j        <= w_j_nxt;
            r_state    <= READ;
            r_emb_re   <= !r_bad;
            r_emb_addr <= {r_id, w_j_nxt};
          end else if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_i        <= w_i_nxt;
            r_j        <= '0;
            r_state    <= FETCH;
            r_tok_re   <= 1'b1;
            r_tok_addr <= w_i_nxt;
          end
        end
        DONE: begin
          if (!cs) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // ROM data arrives during WRITE, so the write data is steered combinationally.
  assign act_data = (r_act_we && !r_bad) ? emb_data : '0;

  assign tok_re   = r_tok_re;
  assign tok_addr = r_tok_addr;
  assign emb_re   = r_emb_re;
  assign emb_addr = r_emb_addr;
  assign act_we   = r_act_we;
  assign act_addr = r_act_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule
